apb_master_ctrl: RTL and testbench

//  APB3 master that turns a simple valid/ready command stream into single APB transfers.

---
 rtl/apb_master_ctrl.sv | 168 ++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB3 master converting a valid/ready command stream into single APB transfers
//
// Purpose: accepts one command at a time, runs one APB SETUP/ACCESS transfer for it,
// and returns read data, slave error and timeout status on a valid/ready response.
// Errored responses are counted in a saturating counter.
//
// Ports:
//   PCLK, PRESETn          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_ready is high only while idle
//   cmd_write/addr/wdata   command direction, address and write data
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata              PRDATA on reads, 0 on writes and on timeout
//   rsp_err, rsp_timeout   PSLVERR or timeout; timeout abort flag
//   err_count              saturating count of handshaken responses with rsp_err = 1
//   PSELx..PWDATA          APB master outputs
//   PRDATA/PREADY/PSLVERR  APB slave inputs, only sampled in ACCESS
module apb_master_ctrl #(
   parameter int ADDR_W      = 1,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16,
   parameter int ERRCNT_W    = 16
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic [ERRCNT_W-1:0] err_count,
   output logic                PSELx,
   output logic                PENABLE,
   output logic                PWRITE,
   output logic [ADDR_W-1:0]   PADDR,
   output logic [DATA_W-1:0]   PWDATA,
   input  logic [DATA_W-1:0]   PRDATA,
   input  logic                PREADY,
   input  logic                PSLVERR
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   // Last legal wait count; reaching it with PREADY still low aborts the transfer.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic       accept;
   logic       xfer_done;
   logic       timed_out;
   logic       rsp_hs;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // APB control and handshake outputs decode straight from the state register,
   // so an asynchronous reset drops them immediately.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      PSELx     = 1'b0;
      PENABLE   = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      xfer_done = 1'b0;
      timed_out = 1'b0;
      rsp_hs    = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            PSELx     = 1'b1;
            state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            PSELx   = 1'b1;
            PENABLE = 1'b1;
            if (PREADY) begin
               xfer_done = 1'b1;
               state_nxt = S_RESP;
            end else if (wait_cnt == TIMEOUT_LAST) begin
               timed_out = 1'b1;
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               rsp_hs    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Address/data phase registers: loaded on acceptance, held through ACCESS and while idle.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PWRITE <= 1'b0;
         PADDR  <= '0;
         PWDATA <= '0;
      end else if (accept) begin
         PWRITE <= cmd_write;
         PADDR  <= cmd_addr;
         PWDATA <= cmd_wdata;
      end
   end

   // Wait counter counts ACCESS cycles that saw PREADY low.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wait_cnt <= '0;
      end else if (accept) begin
         wait_cnt <= '0;
      end else if (state == S_ACCESS && !PREADY && !timed_out) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // Response fields are written only when leaving ACCESS, so they stay
   // stable for the whole RESP state regardless of backpressure.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else if (xfer_done) begin
         rsp_rdata   <= PWRITE ? '0 : PRDATA;
         rsp_err     <= PSLVERR;
         rsp_timeout <= 1'b0;
      end else if (timed_out) begin
         rsp_rdata   <= '0;
         rsp_err     <= 1'b1;
         rsp_timeout <= 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         err_count <= '0;
      end else if (rsp_hs && rsp_err && !(&err_count)) begin
         err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - self-checking bench for apb_master_ctrl
module tb_apb_master_ctrl;

   localparam int TIMEOUT = 16;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [0:0]  cmd_addr = 1'b0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic [15:0] err_count;
   logic        PSELx;
   logic        PENABLE;
   logic        PWRITE;
   logic [0:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA = '0;
   logic        PREADY = 1'b1;
   logic        PSLVERR = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   apb_master_ctrl #(
      .ADDR_W(1), .DATA_W(32), .TIMEOUT_CYC(TIMEOUT), .ERRCNT_W(16)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .err_count(err_count),
      .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: a transfer is described by its age in cycles since
   // acceptance; age 1 is the select-only cycle, age >= 2 are enable cycles until a
   // result is recorded.
   bit          m_busy = 0;
   bit          m_resp = 0;
   int          m_age = 0;
   logic        m_pwrite = 0;
   logic [0:0]  m_paddr = 0;
   logic [31:0] m_pwdata = 0;
   logic [31:0] m_rdata = 0;
   bit          m_err = 0;
   bit          m_to = 0;
   int          m_errcnt = 0;

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         m_busy <= 0; m_resp <= 0; m_age <= 0;
         m_pwrite <= 0; m_paddr <= 0; m_pwdata <= 0;
         m_rdata <= 0; m_err <= 0; m_to <= 0; m_errcnt <= 0;
      end else if (!m_busy) begin
         if (cmd_valid) begin
            m_busy <= 1; m_age <= 1;
            m_pwrite <= cmd_write; m_paddr <= cmd_addr; m_pwdata <= cmd_wdata;
         end
      end else if (m_resp) begin
         if (rsp_ready) begin
            m_busy <= 0; m_resp <= 0; m_age <= 0;
            if (m_err && m_errcnt < 65535) m_errcnt <= m_errcnt + 1;
         end
      end else begin
         if (m_age >= 2) begin
            if (PREADY) begin
               m_resp <= 1; m_rdata <= m_pwrite ? 32'h0 : PRDATA;
               m_err <= PSLVERR; m_to <= 0;
            end else if (m_age - 1 == TIMEOUT) begin
               m_resp <= 1; m_rdata <= 32'h0; m_err <= 1; m_to <= 1;
            end
         end
         m_age <= m_age + 1;
      end
   end

   always @(negedge PCLK) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
      chk("PSELx", 64'(PSELx), 64'(m_busy && !m_resp));
      chk("PENABLE", 64'(PENABLE), 64'(m_busy && !m_resp && m_age >= 2));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_resp));
      chk("PWRITE", 64'(PWRITE), 64'(m_pwrite));
      chk("PADDR", 64'(PADDR), 64'(m_paddr));
      chk("PWDATA", 64'(PWDATA), 64'(m_pwdata));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
      chk("rsp_timeout", 64'(rsp_timeout), 64'(m_to));
      chk("err_count", 64'(err_count), 64'(m_errcnt));
   end

   // One transfer. waits < 0 keeps PREADY low forever. lat counts cycles from the
   // accept edge to the first rsp_valid cycle; en counts enable cycles.
   task automatic xfer(input bit wr, input logic [0:0] addr, input logic [31:0] wd,
                       input int waits, input bit slverr, input logic [31:0] rd,
                       input int hold, output int lat, output int en,
                       output logic [31:0] r_rdata, output logic r_err, output logic r_to);
      bit seen;
      @(posedge PCLK); #2;
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      @(posedge PCLK); #2;
      cmd_valid = 0; cmd_wdata = 32'hFFFF_FFFF; cmd_write = ~wr;
      PREADY = 1; PSLVERR = 1; PRDATA = rd;
      lat = 0; en = 0; seen = 0;
      r_rdata = 'x; r_err = 'x; r_to = 'x;
      for (int c = 1; c <= 60; c++) begin
         @(negedge PCLK);
         if (rsp_valid) begin
            lat = c; seen = 1;
            r_rdata = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
            break;
         end
         if (PENABLE) begin
            en++;
            PREADY = (waits >= 0) && (en > waits);
            PSLVERR = slverr;
         end
      end
      if (!seen) chk("rsp_valid_timeout", 64'(0), 64'(1));
      for (int h = 0; h < hold; h++) begin
         @(negedge PCLK);
         chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
         chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      end
      rsp_ready = 1;
      @(negedge PCLK);
      rsp_ready = 0; PREADY = 1; PSLVERR = 0;
   endtask

   initial begin
      int          lat, en;
      logic [31:0] rd;
      logic        er, to;

      repeat (2) @(posedge PCLK);
      #2 PRESETn = 1;
      @(negedge PCLK);
      chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("reset_PSELx", 64'(PSELx), 64'(0));
      chk("reset_err_count", 64'(err_count), 64'(0));

      // Write then read with zero wait states.
      xfer(1, 1'b0, 32'hA5A5_0001, 0, 0, 32'h1234_5678, 0, lat, en, rd, er, to);
      chk("t1_wr_latency", 64'(lat), 64'(3));
      chk("t1_wr_en_cycles", 64'(en), 64'(1));
      chk("t1_wr_rdata", 64'(rd), 64'(0));
      xfer(0, 1'b1, 32'h0, 0, 0, 32'hA5A5_0001, 0, lat, en, rd, er, to);
      chk("t1_rd_latency", 64'(lat), 64'(3));
      chk("t1_rd_rdata", 64'(rd), 64'hA5A5_0001);
      chk("t1_rd_err", 64'(er), 64'(0));

      // Three wait states.
      xfer(1, 1'b0, 32'h0BAD_F00D, 3, 0, 32'h0, 0, lat, en, rd, er, to);
      chk("t2_en_cycles", 64'(en), 64'(4));
      chk("t2_latency", 64'(lat), 64'(6));

      // Slave error on a read.
      xfer(0, 1'b1, 32'h0, 1, 1, 32'hCAFE_0000, 0, lat, en, rd, er, to);
      chk("t3_err", 64'(er), 64'(1));
      chk("t3_timeout", 64'(to), 64'(0));
      chk("t3_err_count", 64'(err_count), 64'(1));

      // Timeout: PREADY never rises.
      xfer(0, 1'b1, 32'h0, -1, 0, 32'hDEAD_BEEF, 0, lat, en, rd, er, to);
      chk("t4_en_cycles", 64'(en), 64'(16));
      chk("t4_err", 64'(er), 64'(1));
      chk("t4_timeout", 64'(to), 64'(1));
      chk("t4_rdata", 64'(rd), 64'(0));
      chk("t4_err_count", 64'(err_count), 64'(2));

      // Response backpressure for 5 cycles.
      xfer(0, 1'b0, 32'h0, 0, 0, 32'h5A5A_C3C3, 5, lat, en, rd, er, to);
      chk("t5_rdata", 64'(rd), 64'h5A5A_C3C3);
      chk("t5_err_count", 64'(err_count), 64'(2));

      // Reset pulse during ACCESS.
      @(posedge PCLK); #2;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 1'b1; cmd_wdata = 32'h7777_0000;
      @(posedge PCLK); #2;
      cmd_valid = 0; PREADY = 0;
      @(negedge PCLK);
      @(negedge PCLK);
      chk("t5_in_access", 64'(PENABLE), 64'(1));
      #2 PRESETn = 0;
      #1;
      chk("t5_rst_PSELx", 64'(PSELx), 64'(0));
      chk("t5_rst_PENABLE", 64'(PENABLE), 64'(0));
      chk("t5_rst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("t5_rst_err_count", 64'(err_count), 64'(0));
      chk("t5_rst_PWDATA", 64'(PWDATA), 64'(0));
      @(posedge PCLK); #2;
      PRESETn = 1; PREADY = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge PCLK);
         chk("t5_no_rsp", 64'(rsp_valid), 64'(0));
      end

      // Recovery after reset.
      xfer(0, 1'b1, 32'h0, 0, 0, 32'h0000_00C1, 0, lat, en, rd, er, to);
      chk("t6_latency", 64'(lat), 64'(3));
      chk("t6_rdata", 64'(rd), 64'h0000_00C1);

      repeat (2) @(negedge PCLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
